uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_if.sv | 27 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM state encoding and default bit timing.
// Both the RX and TX sides of the UART import this package.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART signal bundle: serial line in, received byte and status out.
// The master modport is the receiver; the slave modport is the line driver and byte consumer.
interface uart_rx_if;

    logic       Serial_IN;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       FRAME_ERR;
    logic       BUSY;

    modport master (
        input  Serial_IN,
        output RX_DATA,
        output RX_VALID,
        output FRAME_ERR,
        output BUSY
    );

    modport slave (
        output Serial_IN,
        input  RX_DATA,
        input  RX_VALID,
        input  FRAME_ERR,
        input  BUSY
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter, so an idle-high line does not look like an edge out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so that both flops
    // sample their inputs from before the edge; a blocking assignment would let
    // d fall straight through to q in a single cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, finds the start edge, samples mid-bit,
// and reports each frame as a one-cycle RX_VALID or FRAME_ERR pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic      CLK,
    input  logic      RST_N,
    uart_rx_if.master rx
);

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    uart_state_t state;
    uart_state_t state_next;

    logic        line;
    logic        line_prev;
    logic        sample;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        frame_err_q;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (rx.Serial_IN),
        .q     (line)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default before the case so no path
    // leaves it unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_next = state;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (line_prev && !line) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    sample     = 1'b1;
                    state_next = line ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    sample = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    sample     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The counter also restarts at each sample point so DATA re-times every bit
    // from the middle of the previous one.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            line_prev   <= 1'b1;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            line_prev   <= line;

            if ((state_next != state) || sample) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end

            if ((state == DATA) && sample) begin
                shreg   <= {line, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            if ((state == STOP) && sample) begin
                if (line) begin
                    rx_data_q  <= shreg;
                    rx_valid_q <= 1'b1;
                end else begin
                    frame_err_q <= 1'b1;
                end
            end
        end
    end

    assign rx.RX_DATA   = rx_data_q;
    assign rx.RX_VALID  = rx_valid_q;
    assign rx.FRAME_ERR = frame_err_q;
    assign rx.BUSY      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: nominal, back-to-back, framing error,
// glitch, mid-frame reset and fast-baud frames, with pulse counting from a negedge monitor.
module tb_uart_rx;

    localparam int CPB = 16;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    uart_rx_if rxi ();

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .rx    (rxi)
    );

    always #5 CLK = ~CLK;

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int both_cnt  = 0;
    int busy_cnt  = 0;
    int valid_cyc = 0;
    logic [7:0] data_log [0:31];

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (rxi.RX_VALID) begin
            data_log[valid_cnt[4:0]] = rxi.RX_DATA;
            valid_cnt++;
            valid_cyc = cyc;
        end
        if (rxi.FRAME_ERR) ferr_cnt++;
        if (rxi.RX_VALID && rxi.FRAME_ERR) both_cnt++;
        if (rxi.BUSY) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        rxi.Serial_IN = b;
        repeat (n) @(negedge CLK);
    endtask

    function automatic int bit_len(input logic fast, input int i);
        if (!fast) return CPB;
        return (i % 2 == 0) ? CPB - 1 : CPB;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic fast,
                              output int start_cyc);
        start_cyc = cyc;
        send_bit(1'b0, bit_len(fast, 0));
        for (int i = 0; i < 8; i++) send_bit(d[i], bit_len(fast, i + 1));
        send_bit(stop, bit_len(fast, 9));
    endtask

    initial begin
        int v0, f0, b0, sc, lat;

        rxi.Serial_IN = 1'b1;
        RST_N         = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_rx_data",   32'(rxi.RX_DATA),   32'h00);
        check("reset_rx_valid",  32'(rxi.RX_VALID),  32'h0);
        check("reset_frame_err", 32'(rxi.FRAME_ERR), 32'h0);
        check("reset_busy",      32'(rxi.BUSY),      32'h0);
        RST_N = 1'b1;
        send_bit(1'b1, 2 * CPB);

        // 0xA5 nominal frame
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, sc);
        send_bit(1'b1, 2 * CPB);
        lat = valid_cyc - sc;
        check("a5_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        check("a5_rx_data",      32'(rxi.RX_DATA),    32'hA5);
        check("a5_frame_err",    32'(ferr_cnt - f0),  32'd0);
        check("a5_busy_after",   32'(rxi.BUSY),       32'h0);
        check("a5_latency_ok",   32'((lat >= 154) && (lat <= 156)), 32'd1);

        // back-to-back 0x00 then 0xFF
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 1'b1, 1'b0, sc);
        send_frame(8'hFF, 1'b1, 1'b0, sc);
        send_bit(1'b1, 2 * CPB);
        check("b2b_valid_pulses", 32'(valid_cnt - v0),             32'd2);
        check("b2b_first_data",   32'(data_log[v0[4:0]]),          32'h00);
        check("b2b_second_data",  32'(data_log[5'(v0 + 1)]),       32'hFF);
        check("b2b_frame_err",    32'(ferr_cnt - f0),              32'd0);

        // 0x3C with stop low, then break for 40 bit times
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, sc);
        send_bit(1'b0, 40 * CPB);
        send_bit(1'b1, 4 * CPB);
        check("brk_frame_err",   32'(ferr_cnt - f0),  32'd1);
        check("brk_no_valid",    32'(valid_cnt - v0), 32'd0);
        check("brk_rx_data_kept", 32'(rxi.RX_DATA),   32'hFF);
        check("brk_busy_after",  32'(rxi.BUSY),       32'h0);

        // 4-cycle low glitch: START for 8 cycles then back to IDLE
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        send_bit(1'b0, 4);
        send_bit(1'b1, 4 * CPB);
        check("glitch_busy_cycles", 32'(busy_cnt - b0),  32'd8);
        check("glitch_no_valid",    32'(valid_cnt - v0), 32'd0);
        check("glitch_no_ferr",     32'(ferr_cnt - f0),  32'd0);

        // reset during data bit 4 of 0x55, then 0x81
        v0 = valid_cnt; f0 = ferr_cnt;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bit(i % 2 == 0, CPB);
        send_bit(1'b1, CPB / 2);
        RST_N = 1'b0;
        send_bit(1'b1, 1);
        RST_N = 1'b1;
        check("rst_busy_cleared",  32'(rxi.BUSY),    32'h0);
        check("rst_rx_data_clear", 32'(rxi.RX_DATA), 32'h00);
        send_bit(1'b1, 10 * CPB);
        send_frame(8'h81, 1'b1, 1'b0, sc);
        send_bit(1'b1, 2 * CPB);
        check("rst_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        check("rst_rx_data",      32'(rxi.RX_DATA),    32'h81);
        check("rst_no_ferr",      32'(ferr_cnt - f0),  32'd0);

        // 0x5A at +3% baud
        v0 = valid_cnt;
        send_frame(8'h5A, 1'b1, 1'b1, sc);
        send_bit(1'b1, 2 * CPB);
        check("fast_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        check("fast_rx_data",      32'(rxi.RX_DATA),    32'h5A);

        check("never_both_pulses", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
